tug_referee: RTL
================

Name: tug_referee

Overview:
Round/match controller for the tug-of-war playfield, a chain of per-position light FSMs driven by left/right moves. It gates player presses into move pulses, detects when a player pushes past an end light, and awards the point. It then holds a point display, re-centres the playfield through a field reset, and ends the match at a target score. It sits between the key-press conditioning logic and the playfield light chain, and drives the score displays.

Parameters:
WIN_SCORE, 7, points needed to win the match (1..2^SCORE_W-1)
HOLD_CYCLES, 4, cycles the POINT state holds before re-serve (>=1)
SCORE_W, 3, width of each score counter

Ports:
Clock  input  1  system clock; all state changes on posedge
reset  input  1  synchronous, active-low; 0 at a posedge resets the block
L  input  1  left player press, single-cycle pulse from upstream conditioning
R  input  1  right player press, single-cycle pulse
leftEdge  input  1  outermost-left playfield light is lit
rightEdge  input  1  outermost-right playfield light is lit
fieldReset  output  1  active-high reset to playfield lights, re-centres the field
moveL  output  1  registered left-move pulse to playfield
moveR  output  1  registered right-move pulse to playfield
scoreL  output  SCORE_W  left player score
scoreR  output  SCORE_W  right player score
pointL  output  1  high while displaying a point awarded to left
pointR  output  1  high while displaying a point awarded to right
gameOver  output  1  high once either score reaches WIN_SCORE

Behaviour:
- All outputs are registered. Nothing is combinational from the inputs.
- Reset (reset==0 at posedge), applied from any state including mid-POINT:
  - next state SERVE;
  - scoreL=scoreR=0;
  - moveL=moveR=0, pointL=pointR=0, gameOver=0;
  - fieldReset=1;
  - hold counter=0.
- States are SERVE, PLAY, POINT and OVER.
- SERVE:
  - fieldReset=1 for exactly one cycle;
  - moves suppressed;
  - always goes to PLAY next cycle.
- PLAY, in priority order:
  - Win-left: leftEdge & L & ~R. Go to POINT, award left, moveL=0.
  - Win-right: rightEdge & R & ~L. Go to POINT, award right, moveR=0.
  - Otherwise moveL <= L & ~R and moveR <= R & ~L. Each move pulse appears 1 cycle after its press and lasts 1 cycle.
  - Simultaneous L&R: no move, no point, stay in PLAY.
  - leftEdge&rightEdge both high (illegal field): only the press matching its own edge can score, so neither win condition can fire together with the other.
- Entering POINT:
  - winner's score increments by 1;
  - pointL or pointR is set, exactly one;
  - hold counter loads HOLD_CYCLES-1;
  - moves forced 0 and all presses ignored;
  - fieldReset=0.
- POINT exit after HOLD_CYCLES cycles (counter reaches 0):
  - pointX clears;
  - if the winner's score == WIN_SCORE, go to OVER;
  - else go to SERVE.
- OVER:
  - gameOver=1;
  - scores frozen;
  - moves 0, presses ignored;
  - fieldReset held 1 so the field stays centred;
  - left only by reset.
- Scores saturate at WIN_SCORE and never wrap; increments are only possible in PLAY->POINT.
- Latency: a winning press to the score update is 1 cycle. A winning press to the fieldReset pulse is HOLD_CYCLES+1 cycles when the match continues.

Test Plan:
- Reset with reset=0 for 2 cycles, then reset=1 -> scores=0, fieldReset=1 during reset and for the first SERVE cycle, then 0; PLAY entered on cycle 2 after release.
- In PLAY, pulse L, then R, then L&R together -> moveL high 1 cycle after L; moveR high 1 cycle after R; no move and no state change for L&R.
- Hold leftEdge=1 and pulse L -> next cycle scoreL=1, pointL=1, moveL=0. pointL stays high 4 cycles, then fieldReset=1 for 1 cycle, then PLAY. Presses during POINT produce no moves.
- rightEdge=1 with L pulse -> normal moveL, no point. rightEdge=1 with R pulse -> scoreR increments.
- Award right 7 times -> after the 7th hold, gameOver=1, scoreR=7, fieldReset stays 1. Further L/R/edge activity changes nothing.
- Assert reset=0 during the 2nd cycle of a POINT hold -> next cycle scores=0, pointL/pointR=0, state SERVE.

Source files
------------

// File: rtl/tug_referee.sv
// Tug-of-war round/match referee.
// Turns player presses into registered move pulses, awards a point when a
// player pushes past their end light, holds the point display, re-centres
// the playfield and stops the match once a player reaches the target score.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_SERVE | one-cycle field re-centre, presses ignored
//   ST_PLAY  | presses become move pulses, edge pushes award points
//   ST_POINT | point display hold, presses ignored
//   ST_OVER  | match decided, everything frozen until reset
module tug_referee #(
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 4,
    parameter int SCORE_W     = 3
) (
    input  logic               Clock,
    input  logic               reset,
    input  logic               L,
    input  logic               R,
    input  logic               leftEdge,
    input  logic               rightEdge,
    output logic               fieldReset,
    output logic               moveL,
    output logic               moveR,
    output logic [SCORE_W-1:0] scoreL,
    output logic [SCORE_W-1:0] scoreR,
    output logic               pointL,
    output logic               pointR,
    output logic               gameOver
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);

    typedef enum logic [1:0] {
        ST_SERVE,
        ST_PLAY,
        ST_POINT,
        ST_OVER
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [SCORE_W-1:0]  score_l_q, score_l_d;
    logic [SCORE_W-1:0]  score_r_q, score_r_d;
    logic                move_l_q, move_l_d;
    logic                move_r_q, move_r_d;
    logic                point_l_q, point_l_d;
    logic                point_r_q, point_r_d;
    logic                game_over_q, game_over_d;
    logic                field_reset_q, field_reset_d;

    logic                win_l, win_r;
    logic [SCORE_W-1:0]  winner_score;

    // A press only scores when it pushes off the player's own end light;
    // a simultaneous opposing press cancels it.
    assign win_l = leftEdge  & L & ~R;
    assign win_r = rightEdge & R & ~L;
    assign winner_score = point_l_q ? score_l_q : score_r_q;

    // Next-state and next-output logic; outputs are computed one cycle early
    // so every port comes straight from a flop.
    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        score_l_d     = score_l_q;
        score_r_d     = score_r_q;
        move_l_d      = 1'b0;
        move_r_d      = 1'b0;
        point_l_d     = point_l_q;
        point_r_d     = point_r_q;
        game_over_d   = game_over_q;
        field_reset_d = 1'b0;

        case (state_q)
            ST_SERVE: begin
                state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (win_l) begin
                    state_d   = ST_POINT;
                    score_l_d = (score_l_q >= WIN_S) ? score_l_q : score_l_q + SCORE_W'(1);
                    point_l_d = 1'b1;
                    point_r_d = 1'b0;
                    hold_d    = HOLD_LOAD;
                end else if (win_r) begin
                    state_d   = ST_POINT;
                    score_r_d = (score_r_q >= WIN_S) ? score_r_q : score_r_q + SCORE_W'(1);
                    point_l_d = 1'b0;
                    point_r_d = 1'b1;
                    hold_d    = HOLD_LOAD;
                end else begin
                    move_l_d = L & ~R;
                    move_r_d = R & ~L;
                end
            end
            ST_POINT: begin
                if (hold_q == '0) begin
                    point_l_d     = 1'b0;
                    point_r_d     = 1'b0;
                    field_reset_d = 1'b1;
                    if (winner_score == WIN_S) begin
                        state_d     = ST_OVER;
                        game_over_d = 1'b1;
                    end else begin
                        state_d = ST_SERVE;
                    end
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            ST_OVER: begin
                field_reset_d = 1'b1;
                game_over_d   = 1'b1;
            end
            default: begin
                state_d       = ST_SERVE;
                field_reset_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!reset) begin
            state_q       <= ST_SERVE;
            hold_q        <= '0;
            score_l_q     <= '0;
            score_r_q     <= '0;
            move_l_q      <= 1'b0;
            move_r_q      <= 1'b0;
            point_l_q     <= 1'b0;
            point_r_q     <= 1'b0;
            game_over_q   <= 1'b0;
            field_reset_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            score_l_q     <= score_l_d;
            score_r_q     <= score_r_d;
            move_l_q      <= move_l_d;
            move_r_q      <= move_r_d;
            point_l_q     <= point_l_d;
            point_r_q     <= point_r_d;
            game_over_q   <= game_over_d;
            field_reset_q <= field_reset_d;
        end
    end

    assign fieldReset = field_reset_q;
    assign moveL      = move_l_q;
    assign moveR      = move_r_q;
    assign scoreL     = score_l_q;
    assign scoreR     = score_r_q;
    assign pointL     = point_l_q;
    assign pointR     = point_r_q;
    assign gameOver   = game_over_q;

endmodule
